down_counter_timer_ctrl: RTL and testbench

- Sequencing controller for a WIDTH-bit down counter used as a programmable countdown timer.
- Accepts a start command with a load value, optionally prescales the clock, and decrements to zero.
- Signals completion with a one-cycle done pulse; supports pause/resume, abort and auto-reload (periodic) operation.
- Sits between the control logic that issues timing requests and the modules consuming done/count.

---
 rtl/down_counter_timer_ctrl.sv | 129 ++++++++++++
 tb/tb_down_counter_timer_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer_ctrl.sv
// down_counter_timer_ctrl
// Programmable countdown timer sequencer: loads a start value, optionally
// prescales the clock, decrements to zero and raises a one-cycle done pulse.
// Supports pause/resume (HOLD), abort (stop) and periodic auto-reload.
//
// Command semantics: start is a single-cycle command that is accepted only
// when the controller is IDLE (busy=0); while busy it is silently dropped.
// stop and pause are levels sampled every cycle in RUN/HOLD, stop winning
// over pause, and pause winning over a prescale tick.
module down_counter_timer_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             Clk,
    input  logic             ClrN,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic [1:0]       state_dbg
);

    // Prescale counter is at least one bit wide even when PRESCALE is 1.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    PS_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   ps_cnt;
    logic            tick;

    // A decrement tick fires on the last cycle of each prescale period.
    assign tick      = (ps_cnt == PS_LAST);
    assign state_dbg = state;

    // Sequencer: state, counter, prescaler and all outputs are registered here.
    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            state  <= S_IDLE;
            count  <= '0;
            ps_cnt <= '0;
            busy   <= 1'b0;
            paused <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (load_val != '0) begin
                            count  <= load_val;
                            ps_cnt <= '0;
                            state  <= S_RUN;
                            busy   <= 1'b1;
                        end else begin
                            // Zero-length timer completes immediately without going busy.
                            done  <= 1'b1;
                            count <= '0;
                        end
                    end
                end

                S_RUN: begin
                    if (stop) begin
                        state  <= S_IDLE;
                        count  <= '0;
                        ps_cnt <= '0;
                        busy   <= 1'b0;
                    end else if (pause) begin
                        // Count and prescale phase are frozen so resume loses no time.
                        state  <= S_HOLD;
                        paused <= 1'b1;
                    end else if (tick) begin
                        ps_cnt <= '0;
                        if (count > CNT_ONE) begin
                            count <= count - CNT_ONE;
                        end else begin
                            // Terminal tick: count never goes below zero.
                            done <= 1'b1;
                            if (auto_reload && (load_val != '0)) begin
                                count <= load_val;
                            end else begin
                                count <= '0;
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end else begin
                        ps_cnt <= ps_cnt + PS_ONE;
                    end
                end

                S_HOLD: begin
                    if (stop) begin
                        state  <= S_IDLE;
                        count  <= '0;
                        ps_cnt <= '0;
                        busy   <= 1'b0;
                        paused <= 1'b0;
                    end else if (!pause) begin
                        state  <= S_RUN;
                        paused <= 1'b0;
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    count  <= '0;
                    ps_cnt <= '0;
                    busy   <= 1'b0;
                    paused <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_counter_timer_ctrl.sv
// Testbench for down_counter_timer_ctrl: two instances (PRESCALE=1 and 3)
// share one stimulus stream; an elapsed-time reference model predicts the
// outputs after every edge and a negedge monitor compares against it.
module tb_down_counter_timer_ctrl;

    localparam int W  = 4;
    localparam int OW = W + 3;

    // Clock / reset block
    logic Clk  = 1'b0;
    logic ClrN = 1'b0;
    always #5 Clk = ~Clk;

    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         pause = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] load_val = '0;

    logic [W-1:0] count_a, count_b;
    logic         busy_a, busy_b, paused_a, paused_b, done_a, done_b;
    logic [1:0]   state_dbg_a, state_dbg_b;

    down_counter_timer_ctrl #(.WIDTH(W), .PRESCALE(1)) u_ps1 (
        .Clk(Clk), .ClrN(ClrN), .start(start), .stop(stop), .pause(pause),
        .auto_reload(auto_reload), .load_val(load_val), .count(count_a),
        .busy(busy_a), .paused(paused_a), .done(done_a), .state_dbg(state_dbg_a)
    );

    down_counter_timer_ctrl #(.WIDTH(W), .PRESCALE(3)) u_ps3 (
        .Clk(Clk), .ClrN(ClrN), .start(start), .stop(stop), .pause(pause),
        .auto_reload(auto_reload), .load_val(load_val), .count(count_b),
        .busy(busy_b), .paused(paused_b), .done(done_b), .state_dbg(state_dbg_b)
    );

    logic [OW-1:0] act_a, act_b;
    assign act_a = {done_a, busy_a, paused_a, count_a};
    assign act_b = {done_b, busy_b, paused_b, count_b};

    // Scoreboard
    logic [OW-1:0] exp_q0[$];
    logic [OW-1:0] exp_q1[$];
    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got done=%0b busy=%0b paused=%0b count=%0d, want done=%0b busy=%0b paused=%0b count=%0d",
                     name, $time, act[W+2], act[W+1], act[W], act[W-1:0],
                     exp[W+2], exp[W+1], exp[W], exp[W-1:0]);
        end
    endtask

    // Reference model: a timer is "loaded value minus elapsed run cycles /
    // prescale"; completion is when run cycles reach load*prescale.
    // m_st: 0 idle, 1 running, 2 held.
    int m_st[2];
    int m_load[2];
    int m_el[2];
    bit m_done[2];

    function automatic int ps_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic model_step(input int i);
        int ps;
        ps = ps_of(i);
        m_done[i] = 1'b0;
        case (m_st[i])
            0: begin
                if (start) begin
                    if (load_val != 0) begin
                        m_st[i] = 1; m_load[i] = int'(load_val); m_el[i] = 0;
                    end else begin
                        m_done[i] = 1'b1;
                    end
                end
            end
            1: begin
                if (stop) m_st[i] = 0;
                else if (pause) m_st[i] = 2;
                else begin
                    m_el[i]++;
                    if (m_el[i] == m_load[i] * ps) begin
                        m_done[i] = 1'b1;
                        if (auto_reload && load_val != 0) begin
                            m_load[i] = int'(load_val); m_el[i] = 0;
                        end else begin
                            m_st[i] = 0;
                        end
                    end
                end
            end
            default: begin
                if (stop) m_st[i] = 0;
                else if (!pause) m_st[i] = 1;
            end
        endcase
    endtask

    function automatic logic [OW-1:0] model_out(input int i);
        int c;
        c = (m_st[i] == 0) ? 0 : m_load[i] - m_el[i] / ps_of(i);
        return {m_done[i], (m_st[i] != 0), (m_st[i] == 2), W'(c)};
    endfunction

    always @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            for (int i = 0; i < 2; i++) begin
                m_st[i] = 0; m_load[i] = 0; m_el[i] = 0; m_done[i] = 1'b0;
            end
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            model_step(0);
            model_step(1);
            exp_q0.push_back(model_out(0));
            exp_q1.push_back(model_out(1));
        end
    end

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    always @(negedge Clk) begin
        if (ClrN === 1'b0) begin
            check("reset_ps1", act_a, '0);
            check("reset_ps3", act_b, '0);
        end else begin
            if (exp_q0.size() > 0) check("out_ps1", act_a, exp_q0.pop_front());
            if (exp_q1.size() > 0) check("out_ps3", act_b, exp_q1.pop_front());
        end
    end

    // Driver tasks
    task automatic drive(input bit s, input bit sp, input bit p, input bit ar, input logic [W-1:0] lv);
        @(negedge Clk);
        start = s; stop = sp; pause = p; auto_reload = ar; load_val = lv;
    endtask

    task automatic idle_n(input int n, input bit ar);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, ar, load_val);
    endtask

    task automatic async_reset_pulse();
        @(posedge Clk);
        #2 ClrN = 1'b0;
        #1;
        check("async_clr_ps1", act_a, '0);
        check("async_clr_ps3", act_b, '0);
        repeat (2) @(negedge Clk);
        ClrN = 1'b1;
    endtask

    bit pause_lvl;
    bit ar_lvl;

    initial begin
        ClrN = 1'b0;
        repeat (3) @(negedge Clk);
        ClrN = 1'b1;
        idle_n(2, 1'b0);

        // Basic countdown
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
        idle_n(12, 1'b0);

        // Auto-reload, then drop it
        drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
        idle_n(14, 1'b1);
        idle_n(10, 1'b0);

        // Pause mid-run
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        idle_n(2, 1'b0);
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
        idle_n(10, 1'b0);

        // Stop together with pause at count 9, then immediate restart
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd15);
        idle_n(6, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd15);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd4);
        idle_n(15, 1'b0);

        // Zero load value, then start while busy
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        idle_n(3, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
        idle_n(2, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
        idle_n(20, 1'b0);

        // Asynchronous reset mid-count (count=5 on the PRESCALE=1 instance)
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd9);
        idle_n(4, 1'b0);
        async_reset_pulse();
        idle_n(4, 1'b0);

        // Randomized phase
        pause_lvl = 1'b0;
        ar_lvl    = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            logic [W-1:0] lv;
            if ($urandom_range(0, 15) == 0) pause_lvl = ~pause_lvl;
            if ($urandom_range(0, 40) == 0) ar_lvl = ~ar_lvl;
            lv = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 15));
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0), pause_lvl, ar_lvl, lv);
            if ($urandom_range(0, 299) == 0) async_reset_pulse();
        end

        idle_n(3, 1'b0);
        @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
